// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute controller for the
// 16-bit ALU datapath. Two-byte fetch, then one execute cycle, or two for
// memory loads/stores. Outputs are decoded combinationally from the current
// state, the instruction register and the zero flag.
module control_sequencer (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  ALU_Flags,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [2:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  RF_ScrSel,
    output logic [4:0]  ALU_FunSel,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [2:0]  ARF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Write,
    output logic        ALU_WF,
    output logic        Mem_CS,
    output logic        Mem_WR,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic        Halted,
    output logic        Illegal
);

    typedef enum logic [2:0] {
        FETCH_L = 3'd0,
        FETCH_H = 3'd1,
        EXEC1   = 3'd2,
        EXEC2   = 3'd3,
        HALT    = 3'd4
    } state_t;

    localparam logic [5:0] OP_BRA = 6'h00;
    localparam logic [5:0] OP_BEQ = 6'h01;
    localparam logic [5:0] OP_BNE = 6'h02;
    localparam logic [5:0] OP_LDI = 6'h03;
    localparam logic [5:0] OP_LD  = 6'h04;
    localparam logic [5:0] OP_ST  = 6'h05;
    localparam logic [5:0] OP_ADD = 6'h06;
    localparam logic [5:0] OP_SUB = 6'h07;
    localparam logic [5:0] OP_AND = 6'h08;
    localparam logic [5:0] OP_ORR = 6'h09;
    localparam logic [5:0] OP_MOV = 6'h0A;
    localparam logic [5:0] OP_HLT = 6'h3F;

    localparam logic [2:0] FUN_LOAD = 3'b010;
    localparam logic [2:0] FUN_INC  = 3'b001;

    state_t      state_r;
    state_t      next_state_s;

    // Instruction fields; register fields only use their low two bits.
    logic [5:0]  op_s;
    logic [1:0]  rsel_s;
    logic        wf_s;
    logic [1:0]  dst_s;
    logic [1:0]  src1_s;
    logic [1:0]  src2_s;
    logic        flag_z_s;
    logic        unused_bits_s;

    assign op_s          = IROut[15:10];
    assign rsel_s        = IROut[9:8];
    assign wf_s          = IROut[9];
    assign dst_s         = IROut[7:6];
    assign src1_s        = IROut[4:3];
    assign src2_s        = IROut[1:0];
    assign flag_z_s      = ALU_Flags[3];
    assign unused_bits_s = ^{IROut[5], IROut[2], ALU_Flags[2:0]};

    // Register index 0..3 maps to R1..R4, with R1 on the most significant bit.
    function automatic logic [3:0] reg_onehot(input logic [1:0] idx);
        logic [3:0] sel;
        case (idx)
            2'd0:    sel = 4'b1000;
            2'd1:    sel = 4'b0100;
            2'd2:    sel = 4'b0010;
            2'd3:    sel = 4'b0001;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

    // ALU function for the register-to-register group; MOV is pass-A.
    function automatic logic [4:0] alu_code(input logic [5:0] op);
        logic [4:0] code;
        case (op)
            OP_ADD:  code = 5'b10100;
            OP_SUB:  code = 5'b10110;
            OP_AND:  code = 5'b10111;
            OP_ORR:  code = 5'b11000;
            default: code = 5'b10000;
        endcase
        return code;
    endfunction

    // State register; reset lands directly in FETCH_L.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r <= FETCH_L;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and control decode; everything starts from the idle set.
    always_comb begin
        next_state_s = state_r;
        RF_OutASel   = 3'b000;
        RF_OutBSel   = 3'b000;
        RF_FunSel    = 3'b000;
        RF_RegSel    = 4'b0000;
        RF_ScrSel    = 4'b0000;
        ALU_FunSel   = 5'b00000;
        ARF_OutCSel  = 2'b00;
        ARF_OutDSel  = 2'b00;
        ARF_FunSel   = 3'b000;
        ARF_RegSel   = 3'b000;
        IR_LH        = 1'b0;
        IR_Write     = 1'b0;
        ALU_WF       = 1'b0;
        Mem_CS       = 1'b1;
        Mem_WR       = 1'b0;
        MuxASel      = 2'b00;
        MuxBSel      = 2'b00;
        MuxCSel      = 1'b0;
        Halted       = 1'b0;
        Illegal      = 1'b0;

        if (!Reset) begin
            // Held in reset: outputs stay idle, the register is forced anyway.
            next_state_s = FETCH_L;
        end else begin
            case (state_r)
                FETCH_L, FETCH_H: begin
                    ARF_OutDSel  = 2'b00;
                    Mem_CS       = 1'b0;
                    IR_Write     = 1'b1;
                    IR_LH        = (state_r == FETCH_H) ? 1'b1 : 1'b0;
                    ARF_RegSel   = 3'b100;
                    ARF_FunSel   = FUN_INC;
                    next_state_s = (state_r == FETCH_H) ? EXEC1 : FETCH_H;
                end
                EXEC1: begin
                    next_state_s = FETCH_L;
                    case (op_s)
                        OP_BRA, OP_BEQ, OP_BNE: begin
                            if ((op_s == OP_BRA) ||
                                ((op_s == OP_BEQ) && flag_z_s) ||
                                ((op_s == OP_BNE) && !flag_z_s)) begin
                                MuxBSel    = 2'b11;
                                ARF_RegSel = 3'b100;
                                ARF_FunSel = FUN_LOAD;
                            end else begin
                                MuxBSel    = 2'b00;
                            end
                        end
                        OP_LDI: begin
                            MuxASel   = 2'b11;
                            RF_FunSel = FUN_LOAD;
                            RF_RegSel = reg_onehot(rsel_s);
                        end
                        OP_LD, OP_ST: begin
                            MuxBSel      = 2'b11;
                            ARF_RegSel   = 3'b010;
                            ARF_FunSel   = FUN_LOAD;
                            next_state_s = EXEC2;
                        end
                        OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_MOV: begin
                            RF_OutASel = {1'b0, src1_s};
                            RF_OutBSel = {1'b0, src2_s};
                            ALU_FunSel = alu_code(op_s);
                            MuxASel    = 2'b00;
                            RF_FunSel  = FUN_LOAD;
                            RF_RegSel  = reg_onehot(dst_s);
                            ALU_WF     = wf_s;
                        end
                        OP_HLT: begin
                            next_state_s = HALT;
                        end
                        default: begin
                            Illegal = 1'b1;
                        end
                    endcase
                end
                EXEC2: begin
                    next_state_s = FETCH_L;
                    case (op_s)
                        OP_LD: begin
                            ARF_OutDSel = 2'b10;
                            Mem_CS      = 1'b0;
                            Mem_WR      = 1'b0;
                            MuxASel     = 2'b10;
                            RF_FunSel   = FUN_LOAD;
                            RF_RegSel   = reg_onehot(rsel_s);
                        end
                        OP_ST: begin
                            RF_OutASel  = {1'b0, rsel_s};
                            ALU_FunSel  = 5'b10000;
                            MuxCSel     = 1'b0;
                            ARF_OutDSel = 2'b10;
                            Mem_CS      = 1'b0;
                            Mem_WR      = 1'b1;
                        end
                        default: begin
                            Mem_CS = 1'b1;
                        end
                    endcase
                end
                HALT: begin
                    Halted       = 1'b1;
                    next_state_s = HALT;
                end
                default: begin
                    next_state_s = FETCH_L;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks a fixed instruction sequence
// and compares the complete control word against hand-built expectations.
module tb_control_sequencer;

    typedef struct packed {
        logic [2:0] rf_outasel;
        logic [2:0] rf_outbsel;
        logic [2:0] rf_funsel;
        logic [3:0] rf_regsel;
        logic [3:0] rf_scrsel;
        logic [4:0] alu_funsel;
        logic [1:0] arf_outcsel;
        logic [1:0] arf_outdsel;
        logic [2:0] arf_funsel;
        logic [2:0] arf_regsel;
        logic       ir_lh;
        logic       ir_write;
        logic       alu_wf;
        logic       mem_cs;
        logic       mem_wr;
        logic [1:0] mux_asel;
        logic [1:0] mux_bsel;
        logic       mux_csel;
        logic       halted;
        logic       illegal;
    } ctl_t;

    logic        clock;
    logic        reset;
    logic [15:0] ir_out;
    logic [3:0]  alu_flags;
    ctl_t        obs_s;

    int n_vec = 0;
    int n_err = 0;

    control_sequencer dut (
        .Clock       (clock),
        .Reset       (reset),
        .IROut       (ir_out),
        .ALU_Flags   (alu_flags),
        .RF_OutASel  (obs_s.rf_outasel),
        .RF_OutBSel  (obs_s.rf_outbsel),
        .RF_FunSel   (obs_s.rf_funsel),
        .RF_RegSel   (obs_s.rf_regsel),
        .RF_ScrSel   (obs_s.rf_scrsel),
        .ALU_FunSel  (obs_s.alu_funsel),
        .ARF_OutCSel (obs_s.arf_outcsel),
        .ARF_OutDSel (obs_s.arf_outdsel),
        .ARF_FunSel  (obs_s.arf_funsel),
        .ARF_RegSel  (obs_s.arf_regsel),
        .IR_LH       (obs_s.ir_lh),
        .IR_Write    (obs_s.ir_write),
        .ALU_WF      (obs_s.alu_wf),
        .Mem_CS      (obs_s.mem_cs),
        .Mem_WR      (obs_s.mem_wr),
        .MuxASel     (obs_s.mux_asel),
        .MuxBSel     (obs_s.mux_bsel),
        .MuxCSel     (obs_s.mux_csel),
        .Halted      (obs_s.halted),
        .Illegal     (obs_s.illegal)
    );

    // 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic ctl_t idle();
        ctl_t c;
        c        = '0;
        c.mem_cs = 1'b1;
        return c;
    endfunction

    function automatic ctl_t fetch(input logic lh);
        ctl_t c;
        c            = idle();
        c.mem_cs     = 1'b0;
        c.ir_write   = 1'b1;
        c.ir_lh      = lh;
        c.arf_regsel = 3'b100;
        c.arf_funsel = 3'b001;
        return c;
    endfunction

    function automatic ctl_t branch();
        ctl_t c;
        c            = idle();
        c.mux_bsel   = 2'b11;
        c.arf_regsel = 3'b100;
        c.arf_funsel = 3'b010;
        return c;
    endfunction

    function automatic ctl_t ar_load();
        ctl_t c;
        c            = idle();
        c.mux_bsel   = 2'b11;
        c.arf_regsel = 3'b010;
        c.arf_funsel = 3'b010;
        return c;
    endfunction

    task automatic check(input string tag, input ctl_t exp);
        n_vec++;
        assert (obs_s === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs_s, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    initial begin
        ctl_t e;
        reset     = 1'b0;
        ir_out    = 16'h0000;
        alu_flags = 4'b0000;

        step();
        step();
        check("reset_idle", idle());

        // Release on a falling edge: FETCH_L is visible straight away.
        reset = 1'b1;
        #1;
        check("first_fetch_l", fetch(1'b0));
        step();
        check("first_fetch_h", fetch(1'b1));

        // LDI R1, 0x2A
        ir_out = 16'h0C2A;
        step();
        e = idle(); e.mux_asel = 2'b11; e.rf_funsel = 3'b010; e.rf_regsel = 4'b1000;
        check("ldi_exec1", e);
        step();
        check("ldi_then_fetch_l", fetch(1'b0));
        step();

        // ADD S=1 D=R2 S1=R2 S2=R3
        ir_out = 16'h1A4A;
        step();
        e = idle(); e.alu_funsel = 5'b10100; e.rf_outasel = 3'b001; e.rf_outbsel = 3'b010;
        e.rf_funsel = 3'b010; e.rf_regsel = 4'b0100; e.alu_wf = 1'b1;
        check("add_exec1", e);
        step();
        check("add_then_fetch_l", fetch(1'b0));
        step();

        // BEQ with Z=1 is taken.
        ir_out = 16'h0455; alu_flags = 4'b1000;
        step();
        check("beq_taken", branch());
        step(); step();

        // BEQ with Z=0 falls through (carry set to show only Z matters).
        alu_flags = 4'b0100;
        step();
        check("beq_not_taken", idle());
        step(); step();

        // BNE with Z=0 is taken, then with Z=1 falls through.
        ir_out = 16'h0812; alu_flags = 4'b0000;
        step();
        check("bne_taken", branch());
        step(); step();
        alu_flags = 4'b1000;
        step();
        check("bne_not_taken", idle());
        step(); step();

        // ST R1 -> 0x80: two execute cycles.
        ir_out = 16'h1480;
        step();
        check("st_exec1", ar_load());
        step();
        e = idle(); e.mem_cs = 1'b0; e.mem_wr = 1'b1; e.arf_outdsel = 2'b10;
        e.rf_outasel = 3'b000; e.alu_funsel = 5'b10000;
        check("st_exec2", e);
        step();
        check("st_then_fetch_l", fetch(1'b0));
        step();

        // LD R2 <- 0x55
        ir_out = 16'h1155;
        step();
        check("ld_exec1", ar_load());
        step();
        e = idle(); e.mem_cs = 1'b0; e.arf_outdsel = 2'b10; e.mux_asel = 2'b10;
        e.rf_funsel = 3'b010; e.rf_regsel = 4'b0100;
        check("ld_exec2", e);
        step();
        check("ld_then_fetch_l", fetch(1'b0));
        step();

        // Unsupported opcode 0x0B pulses Illegal for one cycle.
        ir_out = 16'h2C00;
        step();
        e = idle(); e.illegal = 1'b1;
        check("illegal_exec1", e);
        step();
        check("illegal_then_fetch_l", fetch(1'b0));
        step();

        // MOV R4 <- R3 (pass-A), S=0 keeps flags untouched.
        ir_out = 16'h28D0;
        step();
        e = idle(); e.alu_funsel = 5'b10000; e.rf_outasel = 3'b010; e.rf_outbsel = 3'b000;
        e.rf_funsel = 3'b010; e.rf_regsel = 4'b0001;
        check("mov_exec1", e);
        step(); step();

        // Reset during EXEC2 of an LD.
        ir_out = 16'h1155;
        step();
        step();
        reset = 1'b0;
        #1;
        check("reset_in_exec2", idle());
        step();
        check("reset_held", idle());
        reset = 1'b1;
        #1;
        check("fetch_l_after_reset", fetch(1'b0));
        step();

        // HLT: idle in EXEC1, then Halted held until reset.
        ir_out = 16'hFC00;
        step();
        check("hlt_exec1", idle());
        e = idle(); e.halted = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("halted_%0d", i), e);
        end
        reset = 1'b0;
        #1;
        check("halt_reset_idle", idle());
        step();
        reset = 1'b1;
        #1;
        check("halt_release_fetch_l", fetch(1'b0));
        step();
        check("halt_release_fetch_h", fetch(1'b1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
